// File: rtl/prince_ctrl_pkg.sv
// Shared types and width helpers for the masked PRINCE round controller.
// The state encoding is also what the controller exposes on its debug port.
package prince_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int NUM_ROUNDS_DEF  = 12;
    localparam int SBOX_STAGES_DEF = 2;

    function automatic int round_w(input int num_rounds);
        return (num_rounds <= 2) ? 1 : $clog2(num_rounds);
    endfunction

    function automatic int phase_w(input int sbox_stages);
        return (sbox_stages <= 1) ? 1 : $clog2(sbox_stages);
    endfunction

endpackage

// File: rtl/prince_phase_ctr.sv
// Modulo-STAGES phase counter: walks the S-box pipeline stages once per round,
// gives the one-hot stage enable and a wrap strobe that advances the round.
module prince_phase_ctr
    import prince_ctrl_pkg::*;
#(
    parameter int STAGES = SBOX_STAGES_DEF,
    localparam int PW    = phase_w(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [PW-1:0]     phase,
    output logic              wrap,
    output logic [STAGES-1:0] onehot
);

    localparam logic [PW-1:0] LAST = PW'(STAGES - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= wrap ? '0 : phase + PW'(1);
        end
    end

    always_comb begin
        wrap   = en && (phase == LAST);
        onehot = en ? (STAGES'(1) << phase) : '0;
    end

endmodule

// File: rtl/prince_round_ctrl.sv
// Round controller for the masked PRINCE core: IDLE -> LOAD -> ROUND* -> DONE,
// owning every register-stage enable of the datapath.
module prince_round_ctrl
    import prince_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
    parameter int SBOX_STAGES = SBOX_STAGES_DEF,
    localparam int ROUND_W    = round_w(NUM_ROUNDS),
    localparam int PHASE_W    = phase_w(SBOX_STAGES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   sel_load,
    output logic                   en_state,
    output logic [SBOX_STAGES-1:0] en_sbox,
    output logic                   en_out,
    output logic [ROUND_W-1:0]     round_idx,
    output logic                   sel_inv,
    output logic                   sel_mid,
    output logic [1:0]             dbg_state,
    output logic [PHASE_W-1:0]     dbg_phase
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] HALF       = ROUND_W'(NUM_ROUNDS / 2);
    localparam logic [ROUND_W-1:0] MID        = ROUND_W'(NUM_ROUNDS / 2 - 1);

    // Handshake: start is a level sampled only in IDLE; done is a one-cycle
    // pulse and the output registers hold the result from the next cycle on.
    state_t               state_q, state_d;
    logic [ROUND_W-1:0]   round_q;
    logic                 round_inc, round_clr;
    logic                 ph_en, ph_wrap;
    logic [SBOX_STAGES-1:0] ph_onehot;

    prince_phase_ctr #(.STAGES(SBOX_STAGES)) u_phase (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q != S_ROUND),
        .en     (ph_en),
        .phase  (dbg_phase),
        .wrap   (ph_wrap),
        .onehot (ph_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            if (round_clr) begin
                round_q <= '0;
            end else if (round_inc) begin
                round_q <= round_q + ROUND_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        round_inc = 1'b0;
        round_clr = 1'b0;
        ph_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        sel_load  = 1'b0;
        en_state  = 1'b0;
        en_out    = 1'b0;
        sel_inv   = 1'b0;
        sel_mid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy     = 1'b1;
                sel_load = 1'b1;
                en_state = 1'b1;
                state_d  = S_ROUND;
            end
            S_ROUND: begin
                busy     = 1'b1;
                ph_en    = 1'b1;
                en_state = ph_wrap;
                sel_inv  = (round_q >= HALF);
                sel_mid  = (round_q == MID);
                if (ph_wrap) begin
                    if (round_q == LAST_ROUND) state_d = S_DONE;
                    else                       round_inc = 1'b1;
                end
            end
            S_DONE: begin
                // round_idx still shows the last round here; it returns to 0 with IDLE.
                done      = 1'b1;
                en_out    = 1'b1;
                round_clr = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        en_sbox   = ph_onehot;
        round_idx = round_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Directed bench for prince_round_ctrl: default build plus the (4,3) and (2,1)
// parameter points, each compared cycle by cycle against an offset-based model.
module tb_prince_round_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, start_c;

    logic       busy_a, done_a, sel_load_a, en_state_a, en_out_a, sel_inv_a, sel_mid_a;
    logic [1:0] en_sbox_a;
    logic [3:0] round_idx_a;
    logic [1:0] dbg_state_a;
    logic [0:0] dbg_phase_a;

    logic       busy_b, done_b, sel_load_b, en_state_b, en_out_b, sel_inv_b, sel_mid_b;
    logic [2:0] en_sbox_b;
    logic [1:0] round_idx_b;
    logic [1:0] dbg_state_b;
    logic [1:0] dbg_phase_b;

    logic       busy_c, done_c, sel_load_c, en_state_c, en_out_c, sel_inv_c, sel_mid_c;
    logic [0:0] en_sbox_c;
    logic [0:0] round_idx_c;
    logic [1:0] dbg_state_c;
    logic [0:0] dbg_phase_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prince_round_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .sel_load(sel_load_a), .en_state(en_state_a), .en_sbox(en_sbox_a),
        .en_out(en_out_a), .round_idx(round_idx_a), .sel_inv(sel_inv_a),
        .sel_mid(sel_mid_a), .dbg_state(dbg_state_a), .dbg_phase(dbg_phase_a)
    );

    prince_round_ctrl #(.NUM_ROUNDS(4), .SBOX_STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .sel_load(sel_load_b), .en_state(en_state_b), .en_sbox(en_sbox_b),
        .en_out(en_out_b), .round_idx(round_idx_b), .sel_inv(sel_inv_b),
        .sel_mid(sel_mid_b), .dbg_state(dbg_state_b), .dbg_phase(dbg_phase_b)
    );

    prince_round_ctrl #(.NUM_ROUNDS(2), .SBOX_STAGES(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
        .sel_load(sel_load_c), .en_state(en_state_c), .en_sbox(en_sbox_c),
        .en_out(en_out_c), .round_idx(round_idx_c), .sel_inv(sel_inv_c),
        .sel_mid(sel_mid_c), .dbg_state(dbg_state_c), .dbg_phase(dbg_phase_c)
    );

    // Packed view: {busy,done,sel_load,en_state,en_out,sel_inv,sel_mid,sbox[3:0],ridx[3:0]}
    function automatic logic [14:0] obs_a();
        return {busy_a, done_a, sel_load_a, en_state_a, en_out_a, sel_inv_a, sel_mid_a,
                2'b00, en_sbox_a, round_idx_a};
    endfunction

    function automatic logic [14:0] obs_b();
        return {busy_b, done_b, sel_load_b, en_state_b, en_out_b, sel_inv_b, sel_mid_b,
                1'b0, en_sbox_b, 2'b00, round_idx_b};
    endfunction

    function automatic logic [14:0] obs_c();
        return {busy_c, done_c, sel_load_c, en_state_c, en_out_c, sel_inv_c, sel_mid_c,
                3'b000, en_sbox_c, 3'b000, round_idx_c};
    endfunction

    // Expected outputs k cycles after the IDLE cycle in which start was high.
    function automatic logic [14:0] model(input int k, input int nr, input int ss);
        logic [3:0] sbox, ridx;
        int j, p, r;
        if (k == 1) return 15'b1_0_1_1_0_0_0_0000_0000;
        if (k >= 2 && k <= 1 + nr * ss) begin
            j    = k - 2;
            p    = j % ss;
            r    = j / ss;
            sbox = 4'(1 << p);
            ridx = 4'(r);
            return {1'b1, 1'b0, 1'b0, (p == ss - 1), 1'b0, (r >= nr / 2), (r == nr / 2 - 1),
                    sbox, ridx};
        end
        if (k == 2 + nr * ss) begin
            ridx = 4'(nr - 1);
            return {7'b0100100, 4'b0000, ridx};
        end
        return 15'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_state, n_sb0, n_sb1, n_done;
        rst = 1'b1; start_a = 1'b1; start_b = 1'b0; start_c = 1'b0;

        // Reset, with start asserted alongside it to show reset wins
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("rst_out_%0d", i), 32'(obs_a()), 32'd0);
            chk($sformatf("rst_state_%0d", i), 32'(dbg_state_a), 32'd0);
            chk($sformatf("rst_phase_%0d", i), 32'(dbg_phase_a), 32'd0);
        end
        rst = 1'b0; start_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_%0d", i), 32'(obs_a()), 32'd0);
        end
        chk("idle_b", 32'(obs_b()), 32'd0);
        chk("idle_c", 32'(obs_c()), 32'd0);

        // Single run with default parameters
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n_state = 0; n_sb0 = 0; n_sb1 = 0; n_done = 0;
        for (int k = 1; k <= 28; k++) begin
            chk($sformatf("run1_k%0d", k), 32'(obs_a()), 32'(model(k, 12, 2)));
            n_state += int'(en_state_a);
            n_sb0   += int'(en_sbox_a[0]);
            n_sb1   += int'(en_sbox_a[1]);
            n_done  += int'(done_a);
            if (k < 28) step();
        end
        chk("run1_en_state_pulses", 32'(n_state), 32'd13);
        chk("run1_sbox0_pulses", 32'(n_sb0), 32'd12);
        chk("run1_sbox1_pulses", 32'(n_sb1), 32'd12);
        chk("run1_done_pulses", 32'(n_done), 32'd1);

        // Start held high: second LOAD lands 27 cycles after the first
        step();
        start_a = 1'b1;
        step();
        for (int k = 1; k <= 55; k++) begin
            chk($sformatf("held_k%0d", k), 32'(obs_a()),
                32'(k <= 54 ? model(((k - 1) % 27) + 1, 12, 2) : 15'd0));
            if (k == 53) start_a = 1'b0;
            if (k < 55) step();
        end

        // Reset at round_idx=4, phase=1 (k=11), then a clean run
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) step();
        end
        chk("mid_before_rst", 32'(obs_a()), 32'(model(11, 12, 2)));
        chk("mid_phase", 32'(dbg_phase_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out", 32'(obs_a()), 32'd0);
        chk("mid_rst_state", 32'(dbg_state_a), 32'd0);
        chk("mid_rst_phase", 32'(dbg_phase_a), 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_done += int'(done_a) + int'(busy_a);
        end
        chk("mid_no_done_or_busy", 32'(n_done), 32'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            if (k == 26) chk("mid_restart_done", 32'(done_a), 32'd1);
            else         chk($sformatf("mid_restart_k%0d", k), 32'(obs_a()), 32'(model(k, 12, 2)));
            if (k < 27) step();
        end

        // NUM_ROUNDS=4, SBOX_STAGES=3: done at c+14
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("p43_k%0d", k), 32'(obs_b()), 32'(model(k, 4, 3)));
            if (k == 14) chk("p43_done", 32'(done_b), 32'd1);
            if (k < 16) step();
        end

        // NUM_ROUNDS=2, SBOX_STAGES=1: done at c+4, sel_mid in round 0
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("p21_k%0d", k), 32'(obs_c()), 32'(model(k, 2, 1)));
            if (k == 2) chk("p21_sel_mid_r0", 32'(sel_mid_c), 32'd1);
            if (k == 4) chk("p21_done", 32'(done_c), 32'd1);
            if (k < 6) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
